// File: rtl/pe_ctrl_pkg.sv
// Shared types and constants for the PE control sequencer.
package pe_ctrl_pkg;

  // Job sequencing states.
  typedef enum logic [3:0] {
    StIdle,
    StClr,
    StFetch,
    StMulLd,
    StMulRun,
    StAdd,
    StAccWr,
    StBFetch,
    StBAdd,
    StPFetch,
    StPCmp,
    StOutWr,
    StDone,
    StErr
  } pe_state_e;

  localparam logic MODE_CONV = 1'b0;
  localparam logic MODE_POOL = 1'b1;

  // PE mux select encodings.
  localparam logic SEL_CONV      = 1'b0;
  localparam logic SEL_POOL_BIAS = 1'b1;

  // States that wait on a pe_resp bit and are therefore guarded by the timer.
  function automatic logic is_wait_state(pe_state_e st);
    return (st == StMulRun) || (st == StAdd) || (st == StBAdd);
  endfunction

endpackage

// File: rtl/pe_ctrl_if.sv
// Scheduler and PE signals seen by the controller, bundled as one interface.
interface pe_ctrl_if #(
  parameter int unsigned CNT_W = 8
) ();

  // Scheduler side
  logic             start;
  logic             mode;
  logic [CNT_W-1:0] num_taps;
  logic             use_bias;
  logic             data_vld;
  logic             data_req;
  logic             busy;
  logic             done;
  logic             err;

  // PE side
  logic [1:0]       pe_resp;
  logic             actn_in_sel;
  logic             wt_in_sel;
  logic             add_in_sel;
  logic             pe_out_sel;
  logic             if_rf_wr_en;
  logic             if_rf_rd_en;
  logic             wt_rf_wr_en;
  logic             wt_rf_rd_en;
  logic             of_rf_wr_en;
  logic             of_rf_rd_en;
  logic             mult_en;
  logic             mult_load;
  logic             add_en;
  logic             acc_wr_en;
  logic             acc_clr;

  // Controller view
  modport master (
    input  start, mode, num_taps, use_bias, data_vld, pe_resp,
    output data_req, busy, done, err,
    output actn_in_sel, wt_in_sel, add_in_sel, pe_out_sel,
    output if_rf_wr_en, if_rf_rd_en, wt_rf_wr_en, wt_rf_rd_en, of_rf_wr_en, of_rf_rd_en,
    output mult_en, mult_load, add_en, acc_wr_en, acc_clr
  );

  // Scheduler / PE view
  modport slave (
    output start, mode, num_taps, use_bias, data_vld, pe_resp,
    input  data_req, busy, done, err,
    input  actn_in_sel, wt_in_sel, add_in_sel, pe_out_sel,
    input  if_rf_wr_en, if_rf_rd_en, wt_rf_wr_en, wt_rf_rd_en, of_rf_wr_en, of_rf_rd_en,
    input  mult_en, mult_load, add_en, acc_wr_en, acc_clr
  );

endinterface

// File: rtl/pe_resp_timer.sv
// Loadable up-counter that flags when a wait state has lasted TIMEOUT cycles.
module pe_resp_timer #(
  parameter int unsigned TIMEOUT = 64,
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  output logic            expired_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Expiry is flagged during the TIMEOUT-th enabled cycle so the owner leaves on that edge.
  assign expired_o = en_i && (cnt_q == CntW'(TIMEOUT - 1));

  // Next count: clear wins over load, counting stops once expired.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pe_ctrl.sv
// Sequences one PE through a K-tap conv MAC (optional bias) or a K-sample max-pool.
module pe_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  pe_ctrl_if.master  bus
);

  pe_state_e        state_q, state_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] num_taps_q, num_taps_d;
  logic             use_bias_q, use_bias_d;
  logic             bias_done_q, bias_done_d;
  // One extra bit so the final increment at num_taps = 2^CNT_W-1 cannot wrap.
  logic [CNT_W:0]   tap_cnt_q, tap_cnt_d;
  logic [CNT_W:0]   tap_inc;
  logic             err_q, err_d;

  logic             timer_clr;
  logic             timer_en;
  logic             timer_expired;

  assign tap_inc   = tap_cnt_q + 1'b1;
  assign timer_en  = is_wait_state(state_q);
  // Restart the wait timer on every state change.
  assign timer_clr = (state_d != state_q);

  pe_resp_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk_i      (clk),
    .rst_ni     (rst),
    .clr_i      (timer_clr),
    .en_i       (timer_en),
    .load_i     (1'b0),
    .load_val_i ('0),
    .expired_o  (timer_expired)
  );

  // State and job-context registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      mode_q      <= MODE_CONV;
      num_taps_q  <= '0;
      use_bias_q  <= 1'b0;
      bias_done_q <= 1'b0;
      tap_cnt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      num_taps_q  <= num_taps_d;
      use_bias_q  <= use_bias_d;
      bias_done_q <= bias_done_d;
      tap_cnt_q   <= tap_cnt_d;
      err_q       <= err_d;
    end
  end

  // Next-state and job-context update.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    num_taps_d  = num_taps_q;
    use_bias_d  = use_bias_q;
    bias_done_d = bias_done_q;
    tap_cnt_d   = tap_cnt_q;
    err_d       = err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          mode_d      = bus.mode;
          num_taps_d  = bus.num_taps;
          use_bias_d  = bus.use_bias;
          bias_done_d = 1'b0;
          tap_cnt_d   = '0;
          err_d       = 1'b0;
          state_d     = (bus.num_taps == '0) ? StDone : StClr;
        end
      end
      StClr:    state_d = (mode_q == MODE_CONV) ? StFetch : StPFetch;
      StFetch:  if (bus.data_vld) state_d = StMulLd;
      StMulLd:  state_d = StMulRun;
      StMulRun: begin
        // A response arriving on the expiry cycle still counts as in time.
        if (bus.pe_resp[0]) begin
          state_d = StAdd;
        end else if (timer_expired) begin
          state_d = StErr;
          err_d   = 1'b1;
        end
      end
      StAdd: begin
        if (bus.pe_resp[1]) begin
          state_d = StAccWr;
        end else if (timer_expired) begin
          state_d = StErr;
          err_d   = 1'b1;
        end
      end
      StAccWr: begin
        tap_cnt_d = tap_inc;
        if (tap_inc < {1'b0, num_taps_q}) begin
          state_d = StFetch;
        end else if (use_bias_q && !bias_done_q) begin
          state_d = StBFetch;
        end else begin
          state_d = StOutWr;
        end
      end
      StBFetch: if (bus.data_vld) state_d = StBAdd;
      StBAdd: begin
        if (bus.pe_resp[1]) begin
          bias_done_d = 1'b1;
          state_d     = StAccWr;
        end else if (timer_expired) begin
          state_d = StErr;
          err_d   = 1'b1;
        end
      end
      StPFetch: if (bus.data_vld) state_d = StPCmp;
      StPCmp: begin
        tap_cnt_d = tap_inc;
        state_d   = (tap_inc < {1'b0, num_taps_q}) ? StPFetch : StOutWr;
      end
      StOutWr: state_d = StDone;
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Moore output decode; only the regfile write enables follow data_vld in fetch states.
  always_comb begin
    bus.data_req    = 1'b0;
    bus.actn_in_sel = SEL_CONV;
    bus.wt_in_sel   = SEL_CONV;
    bus.add_in_sel  = SEL_CONV;
    bus.pe_out_sel  = SEL_CONV;
    bus.if_rf_wr_en = 1'b0;
    bus.if_rf_rd_en = 1'b0;
    bus.wt_rf_wr_en = 1'b0;
    bus.wt_rf_rd_en = 1'b0;
    bus.of_rf_wr_en = 1'b0;
    bus.of_rf_rd_en = 1'b0;
    bus.mult_en     = 1'b0;
    bus.mult_load   = 1'b0;
    bus.add_en      = 1'b0;
    bus.acc_wr_en   = 1'b0;
    bus.acc_clr     = 1'b0;
    bus.done        = 1'b0;
    bus.busy        = !((state_q == StIdle) || (state_q == StDone) || (state_q == StErr));
    bus.err         = err_q;
    unique case (state_q)
      StClr: bus.acc_clr = 1'b1;
      StFetch: begin
        bus.data_req    = 1'b1;
        bus.if_rf_wr_en = bus.data_vld;
        bus.wt_rf_wr_en = bus.data_vld;
      end
      StMulLd: begin
        bus.mult_load   = 1'b1;
        bus.if_rf_rd_en = 1'b1;
        bus.wt_rf_rd_en = 1'b1;
      end
      StMulRun: begin
        bus.mult_en     = 1'b1;
        bus.if_rf_rd_en = 1'b1;
        bus.wt_rf_rd_en = 1'b1;
      end
      StAdd:   bus.add_en = 1'b1;
      StAccWr: bus.acc_wr_en = 1'b1;
      StBFetch: begin
        bus.data_req    = 1'b1;
        bus.wt_rf_wr_en = bus.data_vld;
      end
      StBAdd: begin
        bus.wt_in_sel   = SEL_POOL_BIAS;
        bus.wt_rf_rd_en = 1'b1;
        bus.add_in_sel  = SEL_POOL_BIAS;
        bus.add_en      = 1'b1;
      end
      StPFetch: begin
        bus.data_req    = 1'b1;
        bus.if_rf_wr_en = bus.data_vld;
      end
      StPCmp: begin
        bus.actn_in_sel = SEL_POOL_BIAS;
        bus.if_rf_rd_en = 1'b1;
      end
      StOutWr: begin
        bus.pe_out_sel  = mode_q;
        bus.of_rf_wr_en = 1'b1;
      end
      StDone: begin
        bus.done        = 1'b1;
        bus.of_rf_rd_en = 1'b1;
      end
      StErr:   bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pe_ctrl.sv
// Randomised self-checking bench for pe_ctrl with an event-count reference model.
module tb_pe_ctrl;
  import pe_ctrl_pkg::*;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pe_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pe_ctrl #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Per-job event counts, observed from the DUT or predicted by the model.
  typedef struct packed {
    int hs;       // data_req && data_vld beats
    int if_wr;
    int wt_wr;
    int mult_ld;
    int mult_en;  // cycles
    int add_en;   // cycles
    int bias_add; // cycles of bias add (add_in_sel, wt_in_sel, wt_rf_rd_en)
    int acc_wr;
    int acc_clr;
    int pcmp;     // cycles with actn_in_sel && if_rf_rd_en
    int of_wr;
    int out_sel1; // of_rf_wr_en cycles with pe_out_sel=1
    int done;
    int err_done; // done cycles with err=1
    int stray;    // illegal combinations
  } cnt_t;

  int   total = 0;
  int   bad   = 0;
  int   dm_cfg = 4;
  int   da_cfg = 2;
  int   vld_mode = 2;
  bit   noise_en = 1'b1;
  int   cyc = 0;
  cnt_t obs;

  function automatic string fmt(cnt_t c);
    return $sformatf("hs%0d ifw%0d wtw%0d ml%0d me%0d ae%0d ba%0d aw%0d ac%0d pc%0d ow%0d os%0d dn%0d ed%0d st%0d",
                     c.hs, c.if_wr, c.wt_wr, c.mult_ld, c.mult_en, c.add_en, c.bias_add,
                     c.acc_wr, c.acc_clr, c.pcmp, c.of_wr, c.out_sel1, c.done, c.err_done,
                     c.stray);
  endfunction

  function automatic logic [18:0] all_outs();
    return {bus.data_req, bus.actn_in_sel, bus.wt_in_sel, bus.add_in_sel, bus.pe_out_sel,
            bus.if_rf_wr_en, bus.if_rf_rd_en, bus.wt_rf_wr_en, bus.wt_rf_rd_en,
            bus.of_rf_wr_en, bus.of_rf_rd_en, bus.mult_en, bus.mult_load, bus.add_en,
            bus.acc_wr_en, bus.acc_clr, bus.busy, bus.done, bus.err};
  endfunction

  // Reference: what a whole job should produce, from the job parameters and the PE latencies.
  function automatic cnt_t model(bit mode, int n, bit bias, int dm, int da);
    cnt_t e;
    bit   abort;
    bit   is_bias;
    e = '0;
    abort = 1'b0;
    e.done = 1;
    if (n == 0) return e;
    e.acc_clr = 1;
    if (mode) begin
      e.hs = n; e.if_wr = n; e.pcmp = n; e.of_wr = 1; e.out_sel1 = 1;
      return e;
    end
    for (int t = 0; t < n + int'(bias) && !abort; t++) begin
      is_bias = (t == n);
      e.hs += 1;
      e.wt_wr += 1;
      if (!is_bias) begin
        e.if_wr += 1;
        e.mult_ld += 1;
        if (dm > int'(TIMEOUT)) begin
          e.mult_en += TIMEOUT;
          abort = 1'b1;
        end else begin
          e.mult_en += dm;
        end
      end
      if (!abort) begin
        if (da > int'(TIMEOUT)) begin
          e.add_en += TIMEOUT;
          if (is_bias) e.bias_add += TIMEOUT;
          abort = 1'b1;
        end else begin
          e.add_en += da;
          if (is_bias) e.bias_add += da;
          e.acc_wr += 1;
        end
      end
    end
    if (abort) e.err_done = 1;
    else e.of_wr = 1;
    return e;
  endfunction

  // PE/upstream emulator and monitor: drive on negedge, sample 1 time unit later.
  initial begin
    int mcnt;
    int acnt;
    mcnt = 0;
    acnt = 0;
    bus.data_vld = 1'b0;
    bus.pe_resp  = 2'b00;
    obs = '0;
    forever begin
      @(negedge clk);
      cyc++;
      mcnt = bus.mult_en ? mcnt + 1 : 0;
      acnt = bus.add_en ? acnt + 1 : 0;
      bus.pe_resp[0] = bus.mult_en ? (mcnt >= dm_cfg)
                                   : (noise_en && ($urandom_range(0, 3) == 0));
      bus.pe_resp[1] = bus.add_en ? (acnt >= da_cfg)
                                  : (noise_en && ($urandom_range(0, 3) == 0));
      case (vld_mode)
        0:       bus.data_vld = 1'($urandom_range(0, 1));
        1:       bus.data_vld = ~bus.data_vld;
        default: bus.data_vld = 1'b1;
      endcase
      #1;
      if (rst) begin
        if (bus.data_req && bus.data_vld) obs.hs += 1;
        if (bus.if_rf_wr_en) obs.if_wr += 1;
        if (bus.wt_rf_wr_en) obs.wt_wr += 1;
        if ((bus.if_rf_wr_en || bus.wt_rf_wr_en) && !bus.data_req) obs.stray += 1;
        if (bus.mult_load) obs.mult_ld += 1;
        if (bus.mult_en) obs.mult_en += 1;
        if (bus.add_en) obs.add_en += 1;
        if (bus.add_en && bus.add_in_sel && bus.wt_in_sel && bus.wt_rf_rd_en) obs.bias_add += 1;
        if (bus.acc_wr_en) obs.acc_wr += 1;
        if (bus.acc_clr) obs.acc_clr += 1;
        if (bus.actn_in_sel && bus.if_rf_rd_en) obs.pcmp += 1;
        if (bus.of_rf_wr_en) obs.of_wr += 1;
        if (bus.of_rf_wr_en && bus.pe_out_sel) obs.out_sel1 += 1;
        if (bus.pe_out_sel && !bus.of_rf_wr_en) obs.stray += 1;
        if (bus.done) obs.done += 1;
        if (bus.done && bus.err) obs.err_done += 1;
      end
    end
  end

  // Launch one job, optionally poke a second start mid-job, wait (bounded) for done.
  task automatic run_job(input bit mode, input int n, input bit bias, input int dm, input int da,
                         input int vm, input int poke, output bit timed_out);
    dm_cfg   = dm;
    da_cfg   = da;
    vld_mode = vm;
    @(negedge clk);
    obs = '0;
    bus.start    = 1'b1;
    bus.mode     = mode;
    bus.num_taps = CNT_W'(n);
    bus.use_bias = bias;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.mode     = 1'($urandom_range(0, 1));
    bus.num_taps = CNT_W'($urandom);
    bus.use_bias = 1'($urandom_range(0, 1));
    timed_out = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      #2;
      if (poke > 0 && i == poke) begin
        bus.start    = 1'b1;
        bus.mode     = ~mode;
        bus.num_taps = CNT_W'(n + 3);
      end
      if (poke > 0 && i == poke + 1) bus.start = 1'b0;
      if (obs.done != 0) begin
        timed_out = 1'b0;
        break;
      end
    end
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.start = 1'b0; bus.mode = 1'b0; bus.num_taps = '0; bus.use_bias = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    total++;
    if (all_outs() !== 19'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 0", all_outs());
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    total++;
    if (all_outs() !== 19'd0) begin
      bad++;
      $display("FAIL idle_outputs: got %b want 0", all_outs());
    end
  endtask

  task automatic test_conv_basic();
    bit   to;
    cnt_t exp;
    run_job(MODE_CONV, 3, 1'b0, 4, 2, 2, 0, to);
    exp = model(MODE_CONV, 3, 1'b0, 4, 2);
    total++;
    if (to) begin bad++; $display("FAIL conv_basic_done: no done within budget"); end
    total++;
    if (obs.mult_ld !== 3 || obs.acc_wr !== 3 || obs.of_wr !== 1 || obs.out_sel1 !== 0) begin
      bad++;
      $display("FAIL conv_basic_pulses: got ml%0d aw%0d ow%0d os%0d want 3 3 1 0",
               obs.mult_ld, obs.acc_wr, obs.of_wr, obs.out_sel1);
    end
    total++;
    if (obs.mult_en !== 12 || obs.add_en !== 6) begin
      bad++;
      $display("FAIL conv_basic_wait: got me%0d ae%0d want 12 6", obs.mult_en, obs.add_en);
    end
    total++;
    if (obs !== exp) begin bad++; $display("FAIL conv_basic_model: got %s want %s", fmt(obs), fmt(exp)); end
    total++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL conv_basic_status: got err%b busy%b want 0 0", bus.err, bus.busy);
    end
  endtask

  task automatic test_conv_bias();
    bit   to;
    cnt_t exp;
    int   dm;
    int   da;
    dm = $urandom_range(1, 5);
    da = $urandom_range(1, 5);
    run_job(MODE_CONV, 2, 1'b1, dm, da, 0, 0, to);
    exp = model(MODE_CONV, 2, 1'b1, dm, da);
    total++;
    if (to) begin bad++; $display("FAIL conv_bias_done: no done within budget"); end
    total++;
    if (obs.hs !== 3 || obs.if_wr !== 2 || obs.wt_wr !== 3 || obs.acc_wr !== 3) begin
      bad++;
      $display("FAIL conv_bias_beats: got hs%0d ifw%0d wtw%0d aw%0d want 3 2 3 3",
               obs.hs, obs.if_wr, obs.wt_wr, obs.acc_wr);
    end
    total++;
    if (obs.bias_add !== da) begin
      bad++;
      $display("FAIL conv_bias_add: got %0d cycles want %0d", obs.bias_add, da);
    end
    total++;
    if (obs !== exp) begin bad++; $display("FAIL conv_bias_model: got %s want %s", fmt(obs), fmt(exp)); end
  endtask

  task automatic test_pool_gapped();
    bit   to;
    cnt_t exp;
    run_job(MODE_POOL, 4, 1'b0, 3, 3, 1, 0, to);
    exp = model(MODE_POOL, 4, 1'b0, 3, 3);
    total++;
    if (to) begin bad++; $display("FAIL pool_done: no done within budget"); end
    total++;
    if (obs.if_wr !== 4 || obs.pcmp !== 4 || obs.mult_en !== 0 || obs.add_en !== 0) begin
      bad++;
      $display("FAIL pool_counts: got ifw%0d pc%0d me%0d ae%0d want 4 4 0 0",
               obs.if_wr, obs.pcmp, obs.mult_en, obs.add_en);
    end
    total++;
    if (obs.of_wr !== 1 || obs.out_sel1 !== 1) begin
      bad++;
      $display("FAIL pool_out: got ow%0d os%0d want 1 1", obs.of_wr, obs.out_sel1);
    end
    total++;
    if (obs !== exp) begin bad++; $display("FAIL pool_model: got %s want %s", fmt(obs), fmt(exp)); end
  endtask

  task automatic test_timeout();
    bit   to;
    cnt_t exp;
    run_job(MODE_CONV, 1, 1'b0, 1000, 2, 2, 0, to);
    exp = model(MODE_CONV, 1, 1'b0, 1000, 2);
    total++;
    if (to) begin bad++; $display("FAIL timeout_done: no done within budget"); end
    total++;
    if (obs.mult_en !== int'(TIMEOUT) || obs.err_done !== 1 || obs.of_wr !== 0) begin
      bad++;
      $display("FAIL timeout_abort: got me%0d ed%0d ow%0d want %0d 1 0",
               obs.mult_en, obs.err_done, obs.of_wr, TIMEOUT);
    end
    total++;
    if (bus.err !== 1'b1) begin bad++; $display("FAIL timeout_sticky: got err %b want 1", bus.err); end
    total++;
    if (obs !== exp) begin bad++; $display("FAIL timeout_model: got %s want %s", fmt(obs), fmt(exp)); end
    run_job(MODE_CONV, 2, 1'b0, 2, 2, 2, 0, to);
    exp = model(MODE_CONV, 2, 1'b0, 2, 2);
    total++;
    if (to || bus.err !== 1'b0 || obs !== exp) begin
      bad++;
      $display("FAIL timeout_recover: got err%b %s want err0 %s", bus.err, fmt(obs), fmt(exp));
    end
  endtask

  task automatic test_zero_taps();
    cnt_t exp;
    @(negedge clk);
    obs = '0;
    bus.start = 1'b1; bus.mode = MODE_CONV; bus.num_taps = '0; bus.use_bias = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #2;
    total++;
    if (bus.done !== 1'b1) begin bad++; $display("FAIL zero_taps_done: got %b want 1", bus.done); end
    repeat (4) @(negedge clk);
    #2;
    exp = model(MODE_CONV, 0, 1'b1, 1, 1);
    total++;
    if (obs !== exp) begin bad++; $display("FAIL zero_taps_model: got %s want %s", fmt(obs), fmt(exp)); end
  endtask

  task automatic test_busy_start();
    bit   to;
    cnt_t exp;
    run_job(MODE_CONV, 5, 1'b0, 3, 2, 0, 6, to);
    exp = model(MODE_CONV, 5, 1'b0, 3, 2);
    total++;
    if (to || obs !== exp) begin
      bad++;
      $display("FAIL busy_start: got %s want %s", fmt(obs), fmt(exp));
    end
    repeat (10) @(negedge clk);
    #2;
    total++;
    if (obs.done !== 1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_start_single: got dn%0d busy%b want 1 0", obs.done, bus.busy);
    end
  endtask

  task automatic test_mid_reset();
    bit   to;
    bit   seen;
    cnt_t exp;
    dm_cfg = 30; da_cfg = 2; vld_mode = 2;
    @(negedge clk);
    obs = '0;
    bus.start = 1'b1; bus.mode = MODE_CONV; bus.num_taps = CNT_W'(2); bus.use_bias = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      #2;
      if (bus.mult_en) seen = 1'b1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL mid_reset_reach: mult_en never seen"); end
    rst = 1'b0;
    #1;
    total++;
    if (all_outs() !== 19'd0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got %b want 0", all_outs());
    end
    obs = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    total++;
    if (obs.done !== 0) begin bad++; $display("FAIL mid_reset_no_done: got %0d want 0", obs.done); end
    run_job(MODE_CONV, 2, 1'b0, 3, 2, 0, 0, to);
    exp = model(MODE_CONV, 2, 1'b0, 3, 2);
    total++;
    if (to || obs !== exp) begin
      bad++;
      $display("FAIL mid_reset_rerun: got %s want %s", fmt(obs), fmt(exp));
    end
  endtask

  task automatic test_random_jobs();
    bit   to;
    bit   mode;
    bit   bias;
    int   n;
    int   dm;
    int   da;
    cnt_t exp;
    for (int j = 0; j < 12; j++) begin
      mode = 1'($urandom_range(0, 1));
      bias = 1'($urandom_range(0, 1));
      n    = $urandom_range(0, 6);
      dm   = $urandom_range(1, 6);
      da   = $urandom_range(1, 6);
      run_job(mode, n, bias, dm, da, 0, 0, to);
      exp = model(mode, n, bias, dm, da);
      total++;
      if (to || obs !== exp || bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL random_job%0d m%0d n%0d b%0d: got %s want %s",
                 j, mode, n, bias, fmt(obs), fmt(exp));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_conv_basic();
    test_conv_bias();
    test_pool_gapped();
    test_timeout();
    test_zero_taps();
    test_busy_start();
    test_mid_reset();
    test_random_jobs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
